// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the two-requester data-memory arbiter: requester ports, memory port and status.
// The slave modport is the arbiter's view; master is the environment (requesters plus memory).
interface dmem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          m0_req;
    logic          m1_req;
    logic          m0_we;
    logic          m1_we;
    logic [AW-1:0] m0_addr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m1_wdata;
    logic          m0_ack;
    logic          m1_ack;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          grant_id;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
        output m0_ack, m1_ack, rdata, mem_addr, mem_wdata, mem_we, busy, grant_id
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
        input  m0_ack, m1_ack, rdata, mem_addr, mem_wdata, mem_we, busy, grant_id
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> DONE, one transaction per 3 cycles.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m0 always wins a tie.
module dmem_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e        r_state;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_grant;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_mem_we;
    logic          r_busy;
    logic          w_any_req;
    logic          w_pick1;

    assign w_any_req = bus.m0_req | bus.m1_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic r_last;
    // On a tie, m1 wins only when m0 won last.
    assign w_pick1 = bus.m1_req & (~bus.m0_req | ~r_last);
`else
    assign w_pick1 = bus.m1_req & ~bus.m0_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_grant  <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_mem_we <= 1'b0;
            r_busy   <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            r_last   <= 1'b1;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_grant  <= w_pick1;
                        r_we     <= w_pick1 ? bus.m1_we    : bus.m0_we;
                        r_addr   <= w_pick1 ? bus.m1_addr  : bus.m0_addr;
                        r_wdata  <= w_pick1 ? bus.m1_wdata : bus.m0_wdata;
                        r_mem_we <= w_pick1 ? bus.m1_we    : bus.m0_we;
                        r_busy   <= 1'b1;
                        r_state  <= StAccess;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        r_last   <= w_pick1;
`endif
                    end
                end
                StAccess: begin
                    // Captured before the write lands, so writes return the old contents.
                    r_rdata  <= bus.mem_rdata;
                    r_mem_we <= 1'b0;
                    r_ack0   <= ~r_grant;
                    r_ack1   <= r_grant;
                    r_state  <= StDone;
                end
                StDone: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.rdata     = r_rdata;
    assign bus.m0_ack    = r_ack0;
    assign bus.m1_ack    = r_ack1;
    assign bus.busy      = r_busy;
    assign bus.grant_id  = r_grant;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference model predicts grant order and read data,
// a negedge monitor checks every memory write and every ack against the queued expectations.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(8), .DW(8)) bus ();
    dmem_arbiter #(.AW(8), .DW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [256];
    logic       fill_en;
    logic [7:0] fill_a;
    logic [7:0] fill_d;
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (fill_en) mem[fill_a] <= fill_d;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    typedef struct {
        bit         id;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t       q[$];
    logic [7:0] ref_mem [256];
    bit         last_win = 1'b1;
    int         checks = 0;
    int         errors = 0;
    int         we_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per ack, checks memory-side writes against the head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m0_ack && bus.m1_ack) chk("ack_onehot", 32'd2, 32'd1);
            if (bus.mem_we) begin
                we_cnt++;
                if (q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else begin
                    chk("wr_we", {31'd0, bus.mem_we}, {31'd0, q[0].we});
                    chk("wr_addr", {24'd0, bus.mem_addr}, {24'd0, q[0].addr});
                    chk("wr_data", {24'd0, bus.mem_wdata}, {24'd0, q[0].wdata});
                end
            end
            if (bus.m0_ack || bus.m1_ack) begin
                if (q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ack_id", {31'd0, bus.m1_ack}, {31'd0, e.id});
                    chk("grant_id", {31'd0, bus.grant_id}, {31'd0, e.id});
                    chk("rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
                    chk("we_cycles", we_cnt, {31'd0, e.we});
                end
                we_cnt = 0;
            end
        end
    end

    task automatic set_cmd(input bit id, input bit req, input bit we, input logic [7:0] a,
                           input logic [7:0] d);
        if (id) begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end else begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end
    endtask

    task automatic wait_ack(input bit id);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            seen = id ? bus.m1_ack : bus.m0_ack;
        end
        if (!seen) chk("ack_timeout", 32'd0, 32'd1);
        if (id) bus.m1_req = 1'b0;
        else bus.m0_req = 1'b0;
    endtask

    task automatic push_exp(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.id = id; e.we = we; e.addr = a; e.wdata = d; e.rdata = ref_mem[a];
        if (we) ref_mem[a] = d;
        q.push_back(e);
        last_win = id;
    endtask

    // Called with the DUT in IDLE; the first-served requester's inputs are scrambled to
    // (sa, sd) right after its grant edge and must not disturb the transaction in flight.
    task automatic round(input bit r0, input bit r1, input bit we0, input logic [7:0] a0,
                         input logic [7:0] d0, input bit we1, input logic [7:0] a1,
                         input logic [7:0] d1, input logic [7:0] sa, input logic [7:0] sd);
        bit first;
        bit both;
        both  = r0 && r1;
        first = both ? (RrEn ? ~last_win : 1'b0) : r1;
        if (first) push_exp(1'b1, we1, a1, d1);
        else push_exp(1'b0, we0, a0, d0);
        if (both) begin
            if (first) push_exp(1'b0, we0, a0, d0);
            else push_exp(1'b1, we1, a1, d1);
        end
        if (r0) set_cmd(1'b0, 1'b1, we0, a0, d0);
        if (r1) set_cmd(1'b1, 1'b1, we1, a1, d1);
        @(posedge clk); #1;
        set_cmd(first, 1'b1, first ? we1 : we0, sa, sd);
        wait_ack(first);
        if (both) wait_ack(~first);
        @(posedge clk); #1;
    endtask

    task automatic rand_round();
        int p;
        p = $urandom_range(0, 2);
        round(p != 1, p != 0, 1'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int bad;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        fill_en = 1'b1; fill_a = 0; fill_d = 0;
        for (int i = 0; i < 256; i++) begin
            fill_a = 8'(i);
            fill_d = 8'($urandom);
            ref_mem[i] = fill_d;
            @(posedge clk); #1;
        end
        fill_en = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_ack", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        chk("rst_rdata", {24'd0, bus.rdata}, 32'd0);
        chk("rst_grant", {31'd0, bus.grant_id}, 32'd0);
        rst_n = 1'b1;

        round(1, 0, 1, 8'h10, 8'hA5, 0, 8'h00, 8'h00, 8'h10, 8'hA5);
        round(0, 1, 0, 8'h00, 8'h00, 0, 8'h10, 8'h00, 8'h10, 8'h00);
        // In-flight command ignores address change 0x20 -> 0x30.
        round(1, 0, 1, 8'h20, 8'h3C, 0, 8'h00, 8'h00, 8'h30, 8'hC3);
        chk("addr_change_0x20", {24'd0, mem[8'h20]}, {24'd0, ref_mem[8'h20]});
        chk("addr_change_0x30", {24'd0, mem[8'h30]}, {24'd0, ref_mem[8'h30]});
        for (int i = 0; i < 4; i++)
            round(1, 1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 0; i < 40; i++) rand_round();

        // Reset mid-ACCESS of a write: no write, no ack, pointer back to its reset value.
        set_cmd(1'b0, 1'b1, 1'b1, 8'h40, 8'h5A);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_ack", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
        chk("abort_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        set_cmd(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        last_win = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_0x40", {24'd0, mem[8'h40]}, {24'd0, ref_mem[8'h40]});
        round(1, 1, 1, 8'h40, 8'h77, 0, 8'h40, 8'h00, 8'h40, 8'h77);
        for (int i = 0; i < 20; i++) rand_round();

        repeat (4) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("final_mem_mismatches", bad, 32'd0);
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
